pga_gain_writer: RTL
====================

// Module: pga_gain_writer
// PURPOSE
//  Downstream of the gain-decision stage: accepts a signed dB gain request plus a set strobe.
//  Clamps and quantises the request to a PGA code, then serial-writes it to the PGA over a
//  3-wire SPI (mode 0, MSB first). Holds a settle window so level tracking ignores transient data.
//  Coalesces requests that arrive while busy (latest wins).
// PARAMETERS
//  CLK_DIV      4     SCLK half-period in clk cycles (>=1)
//  GAIN_MIN_DB  -8    lowest PGA gain, dB (signed 8b)
//  GAIN_MAX_DB  32    highest PGA gain, dB (signed 8b, > GAIN_MIN_DB)
//  FRAME_W      8     SPI frame bits; code right-aligned, upper bits 0
//  SETTLE_CYC   1000  clk cycles of settle blanking after CS_N rises (>=1)
// PORTS
//  clk             in   1  system clock
//  rst             in   1  async reset, active high
//  gain_dB_i       in   8  signed requested gain, dB
//  set_gain_i      in   1  1-cycle strobe; sample gain_dB_i this cycle
//  sclk_o          out  1  SPI clock, idle low
//  mosi_o          out  1  SPI data, changes while sclk_o low
//  cs_n_o          out  1  PGA chip select, active low
//  busy_o          out  1  high from LOAD through end of SETTLE
//  settling_o      out  1  high LOAD..SETTLE end; consumers discard samples while high
//  gain_applied_o  out  8  signed dB of last written code (clamped value)
//  done_o          out  1  1-cycle pulse on final SETTLE cycle
// BEHAVIOUR
//  Reset (async, immediate, any state):
//   - cs_n_o=1, sclk_o=0, mosi_o=0, busy_o=0, settling_o=0, done_o=0, gain_applied_o=0
//   - state=IDLE, pending cleared, applied_valid=0
//  Clamp: g = min(max(gain_dB_i, GAIN_MIN_DB), GAIN_MAX_DB), signed compare.
//   - code = g - GAIN_MIN_DB (unsigned, ceil(log2(GAIN_MAX_DB-GAIN_MIN_DB+1)) bits)
//  Request capture:
//   - set_gain_i in IDLE: if applied_valid && g==gain_applied_o, ignore (no frame, no done_o).
//     Else go LOAD next cycle.
//   - set_gain_i in any other state: store g in pending reg, set pending flag; later strobes
//     overwrite it. Final SETTLE cycle with pending: done_o pulses, LOAD next cycle with pending
//     value (same equality skip applies), flag cleared.
//  FSM IDLE -> LOAD -> SHIFT -> SETTLE -> IDLE:
//   - LOAD (CLK_DIV cyc): cs_n_o=0, sclk_o=0, mosi_o=frame MSB
//   - SHIFT (2*CLK_DIV*FRAME_W cyc): per bit sclk_o high CLK_DIV cyc, then low CLK_DIV cyc.
//     mosi_o advances on each falling edge; 0 after last bit.
//   - SETTLE (SETTLE_CYC cyc): cs_n_o=1, sclk_o=0; gain_applied_o<=g and applied_valid<=1 on entry.
//  Latency: strobe at cycle N in IDLE -> cs_n_o low at N+1.
//   - cs_n_o high at N+1+CLK_DIV*(2*FRAME_W+1).
//   - done_o at N+CLK_DIV*(2*FRAME_W+1)+SETTLE_CYC (default 1068).
//  Mid-frame reset aborts the frame; applied_valid=0, so the next request always writes.
//  Strobe coincident with done_o cycle is treated as pending; it wins over older pending value.
// TESTING
//  1. Reset, strobe gain=10 (code 18=0x12) -> cs_n low 1 cycle later; MOSI 00010010 on 8 SCLK
//     rising edges; gain_applied_o=10 and done_o at +1068.
//  2. Requests -20 and +50 -> frames 0x00 and 0x28; gain_applied_o=-8 then 32.
//  3. After test 1 completes, strobe 10 again -> no CS activity, no done_o; busy_o stays 0.
//  4. Mid-SHIFT strobes 5 then 7 -> one follow-up frame only, code 15 (7 dB), starting the
//     cycle after done_o.
//  5. Assert rst mid-SHIFT -> cs_n_o=1, sclk_o=0, busy_o=0 same cycle. Strobe 10 after release
//     -> full frame sent (no skip).
//  6. CLK_DIV=1, SETTLE_CYC=1 -> SCLK period 2 clk cycles; done_o exactly 18 cycles after strobe.

Source files
------------

// File: rtl/pga_gain_writer.sv
// PGA gain writer: clamps a signed dB request to a PGA code and shifts it out
// over 3-wire SPI (mode 0, MSB first), then blanks for a settle window.
module pga_gain_writer #(
    parameter int CLK_DIV     = 4,
    parameter int GAIN_MIN_DB = -8,
    parameter int GAIN_MAX_DB = 32,
    parameter int FRAME_W     = 8,
    parameter int SETTLE_CYC  = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic signed [7:0] gain_dB_i,
    input  logic              set_gain_i,
    output logic              sclk_o,
    output logic              mosi_o,
    output logic              cs_n_o,
    output logic              busy_o,
    output logic              settling_o,
    output logic signed [7:0] gain_applied_o,
    output logic              done_o
);
    localparam int CODE_W = $clog2(GAIN_MAX_DB - GAIN_MIN_DB + 1);
    localparam int DW     = $clog2(CLK_DIV + 1);
    localparam int BW     = $clog2(FRAME_W + 1);
    localparam int SW     = $clog2(SETTLE_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_SETTLE} state_t;

    state_t              r_state, w_state_nxt;
    logic [DW-1:0]       r_div;
    logic [BW-1:0]       r_bit;
    logic [SW-1:0]       r_settle;
    logic                r_high;
    logic [FRAME_W-1:0]  r_shift;
    logic signed [7:0]   r_target;
    logic signed [7:0]   r_gain_applied;
    logic                r_applied_valid;
    logic                r_pend;
    logic signed [7:0]   r_pend_g;

    logic signed [7:0]   w_req_g, w_pend_g, w_load_g;
    logic                w_pend_any, w_same_req, w_same_pend;
    logic                w_div_last, w_bit_last, w_settle_last, w_start, w_done;

    function automatic logic signed [7:0] clamp_db(input logic signed [7:0] x);
        if (int'(x) < GAIN_MIN_DB) return 8'(GAIN_MIN_DB);
        if (int'(x) > GAIN_MAX_DB) return 8'(GAIN_MAX_DB);
        return x;
    endfunction

    function automatic logic [FRAME_W-1:0] to_frame(input logic signed [7:0] g);
        logic [CODE_W-1:0] code;
        code = CODE_W'(int'(g) - GAIN_MIN_DB);
        return FRAME_W'(code);
    endfunction

    assign gain_applied_o = r_gain_applied;
    assign w_req_g        = clamp_db(gain_dB_i);
    // A strobe landing on the final settle cycle supersedes any older pending value.
    assign w_pend_any     = set_gain_i | r_pend;
    assign w_pend_g       = set_gain_i ? w_req_g : r_pend_g;
    assign w_same_req     = r_applied_valid && (w_req_g == r_gain_applied);
    assign w_same_pend    = r_applied_valid && (w_pend_g == r_gain_applied);
    assign w_div_last     = (r_div == DW'(CLK_DIV - 1));
    assign w_bit_last     = (r_bit == BW'(FRAME_W - 1));
    assign w_settle_last  = (r_settle == SW'(SETTLE_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_g    = w_req_g;
        cs_n_o      = 1'b1;
        sclk_o      = 1'b0;
        mosi_o      = 1'b0;
        busy_o      = 1'b0;
        settling_o  = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (set_gain_i && !w_same_req) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                cs_n_o     = 1'b0;
                mosi_o     = r_shift[FRAME_W-1];
                busy_o     = 1'b1;
                settling_o = 1'b1;
                if (w_div_last) w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                cs_n_o     = 1'b0;
                sclk_o     = r_high;
                mosi_o     = r_shift[FRAME_W-1];
                busy_o     = 1'b1;
                settling_o = 1'b1;
                if (w_div_last && !r_high && w_bit_last) w_state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                busy_o     = 1'b1;
                settling_o = 1'b1;
                if (w_settle_last) begin
                    w_done   = 1'b1;
                    w_load_g = w_pend_g;
                    w_state_nxt = (w_pend_any && !w_same_pend) ? S_LOAD : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        done_o  = w_done;
        w_start = (w_state_nxt == S_LOAD) && (r_state != S_LOAD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div           <= '0;
            r_bit           <= '0;
            r_settle        <= '0;
            r_high          <= 1'b0;
            r_shift         <= '0;
            r_target        <= '0;
            r_gain_applied  <= '0;
            r_applied_valid <= 1'b0;
            r_pend          <= 1'b0;
            r_pend_g        <= '0;
        end else begin
            if (r_state != S_IDLE && set_gain_i) begin
                r_pend   <= 1'b1;
                r_pend_g <= w_req_g;
            end
            if (w_done) r_pend <= 1'b0;

            if (w_start) begin
                r_target <= w_load_g;
                r_shift  <= to_frame(w_load_g);
                r_div    <= '0;
            end else begin
                case (r_state)
                    S_LOAD: begin
                        if (w_div_last) begin
                            r_div  <= '0;
                            r_high <= 1'b1;
                            r_bit  <= '0;
                        end else begin
                            r_div <= r_div + DW'(1);
                        end
                    end
                    S_SHIFT: begin
                        if (w_div_last) begin
                            r_div <= '0;
                            if (r_high) begin
                                r_high  <= 1'b0;
                                r_shift <= r_shift << 1;
                            end else begin
                                r_high <= 1'b1;
                                r_bit  <= r_bit + BW'(1);
                            end
                            if (w_state_nxt == S_SETTLE) begin
                                r_gain_applied  <= r_target;
                                r_applied_valid <= 1'b1;
                                r_settle        <= '0;
                            end
                        end else begin
                            r_div <= r_div + DW'(1);
                        end
                    end
                    S_SETTLE: r_settle <= r_settle + SW'(1);
                    default: ;
                endcase
            end
        end
    end
endmodule
